// File: rtl/zmips_pkg.sv
// Shared types and defaults for the zmips memory arbiter: FSM state encoding,
// bus owner IDs and the saturating counter helper used by the starvation guard.
package zmips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_STARVE_MAX = 3;

  function automatic owner_t owner_of(arb_state_t s);
    return (s == ST_BUSY_D) ? OWN_D : OWN_I;
  endfunction

  function automatic logic [3:0] sat_inc(logic [3:0] v, logic [3:0] max);
    return (v >= max) ? max : v + 4'd1;
  endfunction

endpackage

// File: rtl/zmips_mem_arbiter_if.sv
// Port bundle of the arbiter: fetch and data request ports plus the shared memory bus.
// slave = arbiter side, master = CPU pipeline / memory side.
interface zmips_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          bus_err;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, bus_err, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, bus_err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/zmips_arb_wdog.sv
// Bus watchdog: counts busy cycles without mem_ready and flags expiry on the
// cycle that reaches TIMEOUT-1. TIMEOUT=0 disables it.
module zmips_arb_wdog
  import zmips_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ready,
  output logic expire
);

  localparam bit         ENABLED = (TIMEOUT != 0);
  localparam logic [7:0] LIMIT   = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt;

  assign expire = ENABLED && busy && !ready && (wd_cnt == LIMIT);

  // Counter restarts whenever the access ends, either way.
  always_ff @(negedge clk) begin
    if (rst || !busy || ready || expire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/zmips_mem_arbiter.sv
// Arbiter sharing one single-ported memory bus between zmips fetch and data
// ports. Data wins ties unless fetch has been passed over STARVE_MAX times.
module zmips_mem_arbiter
  import zmips_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  zmips_mem_arbiter_if.slave bus
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          grant_i, grant_d, done, abort;
  logic          busy, expire, i_elig, d_elig;

  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_rd_q, mem_wr_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic          if_ack_q, d_ack_q, bus_err_q;

  assign busy   = (state_q != ST_IDLE);
  // A port acked this cycle still shows its old req; skip it until next cycle.
  assign i_elig = bus.if_req && !if_ack_q;
  assign d_elig = bus.d_req && !d_ack_q;

  zmips_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy),
    .ready  (bus.mem_ready),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (d_elig && !(i_elig && starve_q == SMAX)) begin
          grant_d  = 1'b1;
          state_d  = ST_BUSY_D;
          starve_d = bus.if_req ? sat_inc(starve_q, SMAX) : 4'd0;
        end else if (i_elig) begin
          grant_i  = 1'b1;
          state_d  = ST_BUSY_I;
          starve_d = 4'd0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // A late mem_ready on the expiry cycle still counts as a completion.
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (expire) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;

      if (grant_d) begin
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        mem_rd_q    <= !bus.d_wr;
        mem_wr_q    <= bus.d_wr;
      end else if (grant_i) begin
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= '0;
        mem_rd_q    <= 1'b1;
        mem_wr_q    <= 1'b0;
      end

      if (done || abort) begin
        mem_rd_q  <= 1'b0;
        mem_wr_q  <= 1'b0;
        bus_err_q <= abort;
        if (owner_of(state_q) == OWN_I) begin
          if_ack_q   <= 1'b1;
          if_rdata_q <= abort ? '0 : bus.mem_rdata;
        end else begin
          d_ack_q <= 1'b1;
          if (abort) begin
            d_rdata_q <= '0;
          end else if (!mem_wr_q) begin
            d_rdata_q <= bus.mem_rdata;
          end
        end
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.bus_err   = bus_err_q;

endmodule
